// File: rtl/fft_pkg.sv
// Shared types and default sizes for the FFT frame sequencer.
package fft_pkg;
  localparam int FFT_M     = 9;
  localparam int FFT_WIDTH = 16;

  typedef logic [2*FFT_WIDTH-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    UNLOAD,
    DONE
  } fft_seq_state_t;
endpackage

// File: rtl/fft_seq_if.sv
// Bus between the frame sequencer and its input buffer, FFT core and output buffer.
interface fft_seq_if import fft_pkg::*; #(
  parameter int M     = FFT_M,
  parameter int WIDTH = FFT_WIDTH
);
  logic               frame_ready;
  logic [M-1:0]       in_rd_adr;
  logic [2*WIDTH-1:0] in_rd_data;
  logic               core_load;
  logic               core_start;
  logic [M-1:0]       core_adr;
  logic [2*WIDTH-1:0] core_wd;
  logic               core_done;
  logic [2*WIDTH-1:0] core_rd;
  logic               out_we;
  logic [M-1:0]       out_adr;
  logic [2*WIDTH-1:0] out_wd;
  logic               frame_done;
  logic               busy;
  logic               overrun;
  logic               timeout_err;

  modport master (
    input  frame_ready, in_rd_data, core_done, core_rd,
    output in_rd_adr, core_load, core_start, core_adr, core_wd,
           out_we, out_adr, out_wd, frame_done, busy, overrun, timeout_err
  );

  modport slave (
    output frame_ready, in_rd_data, core_done, core_rd,
    input  in_rd_adr, core_load, core_start, core_adr, core_wd,
           out_we, out_adr, out_wd, frame_done, busy, overrun, timeout_err
  );
endinterface

// File: rtl/fft_watchdog.sv
// Saturating cycle counter that flags expiry one cycle before reaching TIMEOUT.
module fft_watchdog import fft_pkg::*; #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear)
      r_count <= '0;
    else if (i_enable && (r_count != W'(TIMEOUT)))
      r_count <= r_count + 1'b1;
  end

  assign o_expire = (r_count == W'(TIMEOUT - 1));
endmodule

// File: rtl/fft_seq.sv
// Frame sequencer: copies a frame into the FFT core, starts it, and streams the
// result into the output buffer, with overrun and watchdog error reporting.
module fft_seq import fft_pkg::*; #(
  parameter int M       = FFT_M,
  parameter int WIDTH   = FFT_WIDTH,
  parameter int TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset,
  fft_seq_if.master  bus
);
  fft_seq_state_t r_state, w_next;

  logic [M-1:0] r_count;
  logic [M-1:0] r_out_adr;
  logic         r_term;
  logic         r_out_we;
  logic         r_fr_q;
  logic         r_overrun;
  logic         r_timeout_err;
  logic         w_count_last;
  logic         w_unload_addr;
  logic         w_busy;
  logic         w_wd_expire;

  assign w_count_last  = (r_count == {M{1'b1}});
  assign w_unload_addr = (r_state == UNLOAD) && !r_term;
  assign w_busy        = (r_state != IDLE);

  fft_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (r_state == START),
    .i_enable (r_state == RUN),
    .o_expire (w_wd_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.frame_ready) w_next = LOAD;
      LOAD:    if (w_count_last) w_next = START;
      START:   w_next = RUN;
      RUN: begin
        if (bus.core_done)     w_next = UNLOAD;
        else if (w_wd_expire)  w_next = IDLE;
      end
      UNLOAD:  if (r_term) w_next = DONE;
      DONE:    if (!bus.frame_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The terminal flag buys UNLOAD one extra cycle to retire the last
  // write-back, since core_rd trails core_adr by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count       <= '0;
      r_term        <= 1'b0;
      r_out_we      <= 1'b0;
      r_out_adr     <= '0;
      r_fr_q        <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_fr_q    <= bus.frame_ready;
      r_out_we  <= w_unload_addr;
      r_out_adr <= w_unload_addr ? r_count : '0;
      if (w_busy && bus.frame_ready && !r_fr_q)
        r_overrun <= 1'b1;
      if ((r_state == RUN) && !bus.core_done && w_wd_expire)
        r_timeout_err <= 1'b1;
      if ((r_state == LOAD) || w_unload_addr) begin
        if (w_count_last) begin
          r_count <= '0;
          r_term  <= (r_state == UNLOAD);
        end else begin
          r_count <= r_count + 1'b1;
        end
      end else begin
        r_count <= '0;
        r_term  <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.in_rd_adr   = '0;
    bus.core_load   = 1'b0;
    bus.core_start  = 1'b0;
    bus.core_adr    = '0;
    bus.core_wd     = '0;
    bus.frame_done  = 1'b0;
    bus.out_we      = r_out_we;
    bus.out_adr     = r_out_adr;
    bus.out_wd      = r_out_we ? bus.core_rd : '0;
    bus.busy        = w_busy;
    bus.overrun     = r_overrun;
    bus.timeout_err = r_timeout_err;
    unique case (r_state)
      LOAD: begin
        bus.in_rd_adr = r_count;
        bus.core_load = 1'b1;
        bus.core_adr  = r_count;
        bus.core_wd   = bus.in_rd_data;
      end
      START:   bus.core_start = 1'b1;
      UNLOAD:  if (!r_term) bus.core_adr = r_count;
      DONE:    bus.frame_done = 1'b1;
      default: ;
    endcase
  end
endmodule
